// File: rtl/stream_src_pkg.sv
// Shared constants, FSM state type and LFSR step for the FIFO test-stream source.
package stream_src_pkg;

    localparam logic SRC_MODE_CNT  = 1'b0;
    localparam logic SRC_MODE_LFSR = 1'b1;

    // Counter-mode seeds
    localparam logic [7:0] SRC_SEED_1 = 8'h00;
    localparam logic [7:0] SRC_SEED_2 = 8'h80;

    // LFSR-mode seeds
    localparam logic [7:0] SRC_LFSR_SEED_1 = 8'h01;
    localparam logic [7:0] SRC_LFSR_SEED_2 = 8'hA5;

    // One below full, so a write issued against a stale buf_cnt still fits
    localparam int unsigned SRC_AF_THRESH = 254;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } src_state_e;

    function automatic logic [7:0] src_lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

endpackage

// File: rtl/stream_src_channel.sv
// One stream channel: rate divider, pending flag, payload generator, sent counter.
module stream_src_channel
    import stream_src_pkg::*;
#(
    parameter int unsigned          BUFF_SIZE = 8,
    parameter int unsigned          AF_THRESH = SRC_AF_THRESH,
    parameter int unsigned          PERIOD_W  = 16,
    parameter int unsigned          CNT_W     = 16,
    parameter logic [BUFF_SIZE-1:0] CNT_SEED  = '0,
    parameter logic [BUFF_SIZE-1:0] LFSR_SEED = BUFF_SIZE'(1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init,       // run entry: latch config, reseed, clear
    input  logic                 active,     // in RUN and not being stopped this cycle
    input  logic                 mode,
    input  logic [PERIOD_W-1:0]  period,
    input  logic [CNT_W-1:0]     word_count,
    input  logic [BUFF_SIZE-1:0] buf_cnt,
    output logic                 wr_en,
    output logic [BUFF_SIZE-1:0] data,
    output logic [CNT_W-1:0]     sent,
    output logic                 fin
);

    logic                 mode_q;
    logic [PERIOD_W-1:0]  last_q;     // terminal divider value, max(period,1)-1
    logic [CNT_W-1:0]     wc_q;
    logic [PERIOD_W-1:0]  div_q;
    logic                 pending_q;
    logic [BUFF_SIZE-1:0] gen_q;
    logic [BUFF_SIZE-1:0] gen_next;
    logic [CNT_W-1:0]     sent_q;
    logic                 wr_en_q;
    logic [BUFF_SIZE-1:0] data_q;
    logic                 term;
    logic                 below;
    logic                 issue;

    // Divider terminal count, throttle test, write decision and next payload
    always_comb begin
        term     = active && (div_q == last_q);
        below    = 32'(buf_cnt) < AF_THRESH;
        fin      = (wc_q != '0) && (sent_q == wc_q);
        issue    = active && pending_q && !fin && below;
        gen_next = (mode_q == SRC_MODE_LFSR) ? BUFF_SIZE'(src_lfsr_next(8'(gen_q)))
                                             : gen_q + BUFF_SIZE'(1);
    end

    // Channel state; a terminal count landing on a set pending flag merges into it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= SRC_MODE_CNT;
            last_q    <= '0;
            wc_q      <= '0;
            div_q     <= '0;
            pending_q <= 1'b0;
            gen_q     <= CNT_SEED;
            sent_q    <= '0;
            wr_en_q   <= 1'b0;
            data_q    <= '0;
        end else if (init) begin
            mode_q    <= mode;
            last_q    <= (period == '0) ? '0 : period - PERIOD_W'(1);
            wc_q      <= word_count;
            div_q     <= '0;
            pending_q <= 1'b0;
            gen_q     <= (mode == SRC_MODE_LFSR) ? LFSR_SEED : CNT_SEED;
            sent_q    <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            wr_en_q   <= issue;
            pending_q <= (pending_q && !issue) || term;
            if (active) begin
                div_q <= (div_q == last_q) ? '0 : div_q + PERIOD_W'(1);
            end
            if (issue) begin
                data_q <= gen_q;
                gen_q  <= gen_next;
                // Saturate rather than wrap in endless runs
                if (sent_q != '1) begin
                    sent_q <= sent_q + CNT_W'(1);
                end
            end
        end
    end

    assign wr_en = wr_en_q;
    assign data  = data_q;
    assign sent  = sent_q;

endmodule

// File: rtl/stream_src.sv
// Test-stream source feeding the two input FIFOs; shared run FSM over two channels.
module stream_src
    import stream_src_pkg::*;
#(
    parameter int unsigned          BUFF_SIZE  = 8,
    parameter int unsigned          AF_THRESH  = SRC_AF_THRESH,
    parameter int unsigned          PERIOD_W   = 16,
    parameter int unsigned          CNT_W      = 16,
    parameter logic [BUFF_SIZE-1:0] SEED_CNT_1 = BUFF_SIZE'(SRC_SEED_1),
    parameter logic [BUFF_SIZE-1:0] SEED_CNT_2 = BUFF_SIZE'(SRC_SEED_2),
    parameter logic [BUFF_SIZE-1:0] SEED_LFSR_1 = BUFF_SIZE'(SRC_LFSR_SEED_1),
    parameter logic [BUFF_SIZE-1:0] SEED_LFSR_2 = BUFF_SIZE'(SRC_LFSR_SEED_2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 mode,
    input  logic [PERIOD_W-1:0]  period_1,
    input  logic [PERIOD_W-1:0]  period_2,
    input  logic [CNT_W-1:0]     word_count,
    input  logic [BUFF_SIZE-1:0] buf_cnt_1,
    input  logic [BUFF_SIZE-1:0] buf_cnt_2,
    output logic                 wr_en_1,
    output logic [BUFF_SIZE-1:0] data_1,
    output logic                 wr_en_2,
    output logic [BUFF_SIZE-1:0] data_2,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sent_1,
    output logic [CNT_W-1:0]     sent_2
);

    src_state_e state_q;
    src_state_e state_d;
    logic       init;
    logic       active;
    logic       fin_1;
    logic       fin_2;
    logic       busy_q;
    logic       done_q;

    // Run FSM next state; stop wins over start, start is ignored while running
    always_comb begin
        state_d = state_q;
        init    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d = StRun;
                    init    = 1'b1;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (fin_1 && fin_2) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (start) begin
                    state_d = StRun;
                    init    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == StRun);
            done_q  <= (state_d == StDone);
        end
    end

    // Gating on stop makes wr_en drop the cycle after a stop
    assign active = (state_q == StRun) && !stop;
    assign busy   = busy_q;
    assign done   = done_q;

    stream_src_channel #(
        .BUFF_SIZE (BUFF_SIZE),
        .AF_THRESH (AF_THRESH),
        .PERIOD_W  (PERIOD_W),
        .CNT_W     (CNT_W),
        .CNT_SEED  (SEED_CNT_1),
        .LFSR_SEED (SEED_LFSR_1)
    ) u_ch1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (init),
        .active     (active),
        .mode       (mode),
        .period     (period_1),
        .word_count (word_count),
        .buf_cnt    (buf_cnt_1),
        .wr_en      (wr_en_1),
        .data       (data_1),
        .sent       (sent_1),
        .fin        (fin_1)
    );

    stream_src_channel #(
        .BUFF_SIZE (BUFF_SIZE),
        .AF_THRESH (AF_THRESH),
        .PERIOD_W  (PERIOD_W),
        .CNT_W     (CNT_W),
        .CNT_SEED  (SEED_CNT_2),
        .LFSR_SEED (SEED_LFSR_2)
    ) u_ch2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (init),
        .active     (active),
        .mode       (mode),
        .period     (period_2),
        .word_count (word_count),
        .buf_cnt    (buf_cnt_2),
        .wr_en      (wr_en_2),
        .data       (data_2),
        .sent       (sent_2),
        .fin        (fin_2)
    );

endmodule
